// File: rtl/vga_pkg.sv
// Shared constants, pixel type and font ROM address packing for the
// character renderer and its memory bus.
package vga_pkg;

    localparam int CHR_WIDTH  = 9;
    localparam int CHR_HEIGHT = 16;
    localparam int CHR_COLS   = 70;
    localparam int CHR_ROWS   = 30;
    localparam int CHR_COUNT  = CHR_COLS * CHR_ROWS;

    // 12-bit colour {R4, G4, B4}
    typedef logic [11:0] rgb444_t;

    // Font ROM holds 16 rows per glyph, so the code selects a 16-row block
    function automatic logic [11:0] font_addr_pack(input logic [7:0] code,
                                                   input logic [3:0] row);
        return {code, row};
    endfunction

endpackage

// File: rtl/vga_char_renderer_if.sv
// Read bus from the renderer to the external text RAM and font ROM.
// Both memories return data one clock after the address is presented.
interface vga_char_renderer_if;
    import vga_pkg::CHR_WIDTH;

    logic [11:0]          vram_addr;
    logic [7:0]           vram_data;
    logic [11:0]          font_addr;
    logic [CHR_WIDTH-1:0] font_data;

    modport master (output vram_addr, output font_addr,
                    input  vram_data, input  font_data);
    modport slave  (input  vram_addr, input  font_addr,
                    output vram_data, output font_data);
endinterface

// File: rtl/vga_blink_timer.sv
// Counts vsync rising edges and toggles blink_on every BLINK_FRAMES frames.
module vga_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic pclk,
    input  logic reset,
    input  logic vsync_in,
    output logic blink_on
);

    logic       vsync_q;
    logic [4:0] frame_cnt;
    logic       vsync_rise;

    assign vsync_rise = vsync_in & ~vsync_q;

    // Edge detector history plus frame counter with wrap-and-toggle
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            frame_cnt <= 5'd0;
            blink_on  <= 1'b1;
        end else begin
            vsync_q <= vsync_in;
            if (vsync_rise) begin
                if (frame_cnt == 5'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= 5'd0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_char_renderer.sv
// Text-mode pixel generator: character code lookup, glyph row lookup,
// pixel select, cursor underline and colour output, all timing-aligned
// with the delayed sync/valid strobes.
module vga_char_renderer
    import vga_pkg::rgb444_t;
    import vga_pkg::font_addr_pack;
#(
    parameter int LATENCY          = 3,
    parameter int CHR_WIDTH        = 9,
    parameter int CURSOR_ROW_START = 14,
    parameter int BLINK_FRAMES     = 30
) (
    input  logic                 pclk,
    input  logic                 reset,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 valid_in,
    input  logic                 chr_disp_valid,
    input  logic [11:0]          chr_addr,
    input  logic [3:0]           cur_chr_x,
    input  logic [3:0]           cur_chr_y,
    vga_char_renderer_if.master  mem,
    input  logic [11:0]          cursor_addr,
    input  logic                 cursor_en,
    input  rgb444_t              fg_color,
    input  rgb444_t              bg_color,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 valid_out
);

    localparam logic [3:0] LAST_COL = 4'(CHR_WIDTH - 1);

    logic [3:0]  x_p1, y_p1, x_p2, y_p2;
    logic [11:0] addr_p1, addr_p2;
    logic        disp_p1, disp_p2;
    logic [2:0]  sync_p [1:LATENCY];   // {hsync, vsync, valid}
    logic        vld_p2;
    rgb444_t     rgb_p3;

    logic        blink_on;
    logic [3:0]  pix_idx;
    logic        pix;
    logic        cursor_hit;
    rgb444_t     color;
    rgb444_t     rgb_next;

    vga_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .pclk     (pclk),
        .reset    (reset),
        .vsync_in (vsync_in),
        .blink_on (blink_on)
    );

    // ---- stage 0: text RAM address straight from the controller ----
    assign mem.vram_addr = chr_addr;

    // ---- stage 1: code arrives from text RAM, build glyph row address ----
    assign mem.font_addr = font_addr_pack(mem.vram_data, y_p1);

    // Cell position and display flag ride along with the memory lookups
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            x_p1    <= '0;
            y_p1    <= '0;
            addr_p1 <= '0;
            disp_p1 <= 1'b0;
            x_p2    <= '0;
            y_p2    <= '0;
            addr_p2 <= '0;
            disp_p2 <= 1'b0;
        end else begin
            x_p1    <= cur_chr_x;
            y_p1    <= cur_chr_y;
            addr_p1 <= chr_addr;
            disp_p1 <= chr_disp_valid;
            x_p2    <= x_p1;
            y_p2    <= y_p1;
            addr_p2 <= addr_p1;
            disp_p2 <= disp_p1;
        end
    end

    // Sync and active-video strobes delayed to match the RGB path
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= LATENCY; i++) sync_p[i] <= '0;
        end else begin
            sync_p[1] <= {hsync_in, vsync_in, valid_in};
            for (int i = 2; i <= LATENCY; i++) sync_p[i] <= sync_p[i-1];
        end
    end

    assign vld_p2 = sync_p[2][0];

    // ---- stage 2: glyph row arrives, pick pixel, overlay cursor ----
    // Bit LAST_COL is the leftmost pixel; columns past the glyph are blank
    always_comb begin
        pix_idx    = LAST_COL - x_p2;
        pix        = (x_p2 <= LAST_COL) ? mem.font_data[pix_idx] : 1'b0;
        cursor_hit = cursor_en & blink_on & (addr_p2 == cursor_addr)
                     & (y_p2 >= 4'(CURSOR_ROW_START));
        color      = (pix | cursor_hit) ? fg_color : bg_color;
        if (!vld_p2)       rgb_next = '0;
        else if (!disp_p2) rgb_next = bg_color;
        else               rgb_next = color;
    end

    // ---- stage 3: registered colour output ----
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) rgb_p3 <= '0;
        else       rgb_p3 <= rgb_next;
    end

    assign vga_r = rgb_p3[11:8];
    assign vga_g = rgb_p3[7:4];
    assign vga_b = rgb_p3[3:0];
    assign {hsync_out, vsync_out, valid_out} = sync_p[LATENCY];

endmodule

// File: tb/tb_vga_char_renderer.sv
// Scoreboard bench for vga_char_renderer with behavioural memories.
module tb_vga_char_renderer;

    localparam int BLINK = 30;
    localparam int ROWSTART = 14;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync_in = 1'b1, vsync_in = 1'b0, valid_in = 1'b0, chr_disp_valid = 1'b0;
    logic [11:0] chr_addr = '0;
    logic [3:0]  cur_chr_x = '0, cur_chr_y = '0;
    logic [11:0] cursor_addr = '0;
    logic        cursor_en = 1'b0;
    logic [11:0] fg_color = 12'hFFF, bg_color = 12'h00F;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync_out, vsync_out, valid_out;

    vga_char_renderer_if mem_if();

    vga_char_renderer dut (
        .pclk(pclk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .valid_in(valid_in), .chr_disp_valid(chr_disp_valid), .chr_addr(chr_addr),
        .cur_chr_x(cur_chr_x), .cur_chr_y(cur_chr_y), .mem(mem_if),
        .cursor_addr(cursor_addr), .cursor_en(cursor_en),
        .fg_color(fg_color), .bg_color(bg_color),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .valid_out(valid_out)
    );

    always #5 pclk = ~pclk;

    // External memories with one-cycle registered read
    logic [7:0] vram [0:4095];
    logic [8:0] font [0:4095];
    always @(posedge pclk) begin
        mem_if.vram_data <= vram[mem_if.vram_addr];
        mem_if.font_data <= font[mem_if.font_addr];
    end

    typedef struct {
        int          cyc;
        logic [11:0] rgb;
        logic        hs, vs, vld;
        string       tag;
    } exp_t;

    exp_t  q[$];
    int    cyc = 0;
    int    n_checks = 0, n_fail = 0;
    int    edges = 0;
    logic  vs_prev = 1'b0;
    string tag = "reset";

    always @(posedge pclk) cyc <= cyc + 1;

    // Reference pixel from the text-mode rules
    function automatic logic [11:0] ref_pixel(logic v, logic d, logic [11:0] a,
                                              logic [3:0] x, logic [3:0] y);
        logic [7:0] code;
        logic [8:0] row;
        int         xi;
        bit         pix, blink_on, cur;
        if (!v) return 12'h000;
        if (!d) return bg_color;
        code     = vram[a];
        row      = font[int'(code) * 16 + int'(y)];
        xi       = int'(x);
        pix      = (xi <= 8) ? row[8 - xi] : 1'b0;
        blink_on = ((edges / BLINK) % 2) == 0;
        cur      = cursor_en && blink_on && (a == cursor_addr) && (int'(y) >= ROWSTART);
        return (pix || cur) ? fg_color : bg_color;
    endfunction

    task automatic apply(logic v, logic d, logic [11:0] a, logic [3:0] x,
                         logic [3:0] y, logic hs, logic vs);
        exp_t e;
        valid_in = v; chr_disp_valid = d; chr_addr = a;
        cur_chr_x = x; cur_chr_y = y; hsync_in = hs; vsync_in = vs;
        if (vs && !vs_prev) edges++;
        vs_prev = vs;
        e.cyc = cyc; e.rgb = ref_pixel(v, d, a, x, y);
        e.hs = hs; e.vs = vs; e.vld = v; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic drive(logic v, logic d, logic [11:0] a, logic [3:0] x,
                         logic [3:0] y, logic hs, logic vs);
        @(posedge pclk); #1;
        apply(v, d, a, x, y, hs, vs);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 12'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic check_zero(string name);
        n_checks++;
        if ({vga_r, vga_g, vga_b, hsync_out, vsync_out, valid_out} !== 15'd0) begin
            n_fail++;
            $display("FAIL %s: outputs rgb=%h hs=%b vs=%b vld=%b, required all zero",
                     name, {vga_r, vga_g, vga_b}, hsync_out, vsync_out, valid_out);
        end
    endtask

    task automatic release_reset();
        @(posedge pclk); #1;
        reset = 1'b0;
        edges = 0; vs_prev = 1'b0;
        apply(1'b0, 1'b0, 12'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    endtask

    // Monitor: each scheduled output is checked exactly three cycles after issue
    always @(negedge pclk) begin
        if (!reset && q.size() > 0) begin
            if (q[0].cyc + 3 == cyc) begin
                exp_t e;
                e = q.pop_front();
                n_checks++;
                if ({vga_r, vga_g, vga_b} !== e.rgb || hsync_out !== e.hs ||
                    vsync_out !== e.vs || valid_out !== e.vld) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got rgb=%h hs=%b vs=%b vld=%b, expected rgb=%h hs=%b vs=%b vld=%b",
                             e.tag, cyc, {vga_r, vga_g, vga_b}, hsync_out, vsync_out, valid_out,
                             e.rgb, e.hs, e.vs, e.vld);
                end
            end else if (q[0].cyc + 3 < cyc) begin
                exp_t e;
                e = q.pop_front();
                n_checks++; n_fail++;
                $display("FAIL %s: output slot issued at %0d missed (now %0d)", e.tag, e.cyc, cyc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            vram[i] = 8'($urandom);
            font[i] = 9'($urandom);
        end
        for (int r = 0; r < 16; r++) font[r] = 9'h000;
        vram[0] = 8'h41;
        vram[5] = 8'h00;
        font[12'h413] = 9'b100000001;
        font[12'h417] = 9'h1FF;

        // Reset held with toggling inputs
        for (int i = 0; i < 8; i++) begin
            @(posedge pclk); #1;
            valid_in = 1'($urandom); chr_disp_valid = 1'($urandom);
            hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            chr_addr = 12'($urandom_range(0, 2099)); cur_chr_x = 4'($urandom);
            @(negedge pclk);
            check_zero("reset_hold");
        end
        release_reset();

        // Glyph row 3 of 0x41 across all nine columns
        tag = "glyph_row";
        for (int x = 0; x < 9; x++) drive(1'b1, 1'b1, 12'd0, 4'(x), 4'd3, 1'b1, 1'b0);
        tag = "right_margin";
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 12'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0);
        tag = "blanking";
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 12'd0, 4'd0, 4'd3, 1'b1, 1'b0);

        // Cursor underline on cell 5, enabled then disabled
        cursor_addr = 12'd5; cursor_en = 1'b1;
        tag = "cursor_on";
        for (int y = 0; y < 16; y++) drive(1'b1, 1'b1, 12'd5, 4'd4, 4'(y), 1'b1, 1'b0);
        idle(4);
        cursor_en = 1'b0;
        tag = "cursor_off";
        for (int y = 0; y < 16; y++) drive(1'b1, 1'b1, 12'd5, 4'd4, 4'(y), 1'b1, 1'b0);
        idle(4);

        // Blink: 30 frames hide the cursor, 30 more show it again
        cursor_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            tag = "blink_frames";
            for (int f = 0; f < BLINK; f++) begin
                drive(1'b0, 1'b0, 12'd0, 4'd0, 4'd0, 1'b1, 1'b1);
                drive(1'b0, 1'b0, 12'd0, 4'd0, 4'd0, 1'b1, 1'b1);
                drive(1'b0, 1'b0, 12'd0, 4'd0, 4'd0, 1'b1, 1'b0);
            end
            idle(4);
            tag = (pass == 0) ? "blink_hidden" : "blink_shown";
            for (int y = 12; y < 16; y++) drive(1'b1, 1'b1, 12'd5, 4'd2, 4'(y), 1'b1, 1'b0);
            idle(4);
        end

        // Sync pulses through the pipeline
        tag = "hsync_pulse";
        for (int i = 0; i < 116; i++)
            drive(1'($urandom), 1'($urandom), 12'($urandom_range(0, 2099)), 4'($urandom),
                  4'($urandom), (i >= 10 && i < 106) ? 1'b0 : 1'b1, 1'b0);
        tag = "vsync_pulse";
        for (int i = 0; i < 30; i++)
            drive(1'b0, 1'b0, 12'd0, 4'd0, 4'd0, 1'b1, (i >= 5 && i < 25) ? 1'b1 : 1'b0);
        idle(4);

        // Randomised stream with cursor near a small address pool
        fg_color = 12'($urandom); bg_color = 12'($urandom);
        cursor_addr = 12'd7;
        tag = "random";
        for (int i = 0; i < 300; i++) begin
            logic [11:0] a;
            a = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom_range(0, 2099));
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0), a,
                  4'($urandom), 4'($urandom), ($urandom_range(0, 19) != 0), 1'b0);
        end
        idle(4);

        // Mid-line asynchronous reset and refill
        fg_color = 12'hFFF; bg_color = 12'h00F;
        tag = "pre_reset";
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 12'd0, 4'(i), 4'd7, 1'b1, 1'b0);
        @(posedge pclk); #1;
        reset = 1'b1;
        q.delete();
        #1 check_zero("async_reset");
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            check_zero("reset_mid_line");
        end
        release_reset();
        tag = "refill";
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 12'd0, 4'(i), 4'd7, 1'b1, 1'b0);
        idle(6);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge pclk);
        if (q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain: %0d outputs still pending, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
